// File: rtl/gemm_seq_engine.sv
// gemm_seq_engine: sequential R = alpha*(A x B) + beta*C over signed integers.
// Operands are streamed into A/B/C buffers through a valid/ready load port.
// A single MAC lane produces one result element per K+2 cycles, row-major.
// Results leave on a valid/ready port with row/column tags. Saturation is
// optional, and a sticky overflow flag reports any out-of-range element.
//
// state | meaning
// IDLE  | accept load beats into A/B/C, wait for start
// MAC   | K cycles: acc += A[i][k] * B[k][j]
// SCALE | v = alpha*acc + beta*C[i][j], clamp or wrap into out_data
// EMIT  | hold out_valid until out_ready, then advance (i, j)
// DONE  | one-cycle done pulse, back to IDLE
module gemm_seq_engine #(
  parameter int DATA_WIDTH = 32,
  parameter int M          = 4,
  parameter int K          = 4,
  parameter int N          = 4,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH+$clog2(K)+1
) (
  input  logic                                iclk,
  input  logic                                irst,
  input  logic [DATA_WIDTH-1:0]               alpha,
  input  logic [DATA_WIDTH-1:0]               beta,
  input  logic                                sat_en,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [1:0]                          in_sel,
  input  logic [DATA_WIDTH-1:0]               in_data,
  input  logic                                start,
  output logic                                busy,
  output logic                                done,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [DATA_WIDTH-1:0]               out_data,
  output logic [((M > 1) ? $clog2(M) : 1)-1:0] out_row,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] out_col,
  output logic                                ovf
);

  localparam int DW  = DATA_WIDTH;
  localparam int AW  = ACC_WIDTH;
  localparam int VW  = ACC_WIDTH + DATA_WIDTH + 1;
  localparam int RW  = (M > 1) ? $clog2(M) : 1;
  localparam int CW  = (N > 1) ? $clog2(N) : 1;
  localparam int KW  = (K > 1) ? $clog2(K) : 1;
  localparam int AAW = (M*K > 1) ? $clog2(M*K) : 1;
  localparam int BAW = (K*N > 1) ? $clog2(K*N) : 1;
  localparam int CAW = (M*N > 1) ? $clog2(M*N) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_MAC   = 3'd1;
  localparam logic [2:0] S_SCALE = 3'd2;
  localparam logic [2:0] S_EMIT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0] state;

  logic signed [DW-1:0] a_mem [M*K];
  logic signed [DW-1:0] b_mem [K*N];
  logic signed [DW-1:0] c_mem [M*N];

  logic [AAW-1:0] a_wp;
  logic [BAW-1:0] b_wp;
  logic [CAW-1:0] c_wp;

  logic signed [DW-1:0] alpha_q;
  logic signed [DW-1:0] beta_q;
  logic                 sat_q;

  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [KW-1:0] kk;
  logic signed [AW-1:0] acc;

  logic load_fire;
  logic start_fire;
  logic last_elem;

  logic [AAW-1:0] a_idx;
  logic [BAW-1:0] b_idx;
  logic [CAW-1:0] c_idx;

  logic signed [AW-1:0] a_x;
  logic signed [AW-1:0] b_x;
  logic signed [AW-1:0] prod;

  logic signed [VW-1:0] alpha_x;
  logic signed [VW-1:0] beta_x;
  logic signed [VW-1:0] acc_x;
  logic signed [VW-1:0] c_x;
  logic signed [VW-1:0] v;
  logic                 v_ovf;
  logic [DW-1:0]        v_res;

  // Loading is only possible while idle and out of reset.
  assign in_ready   = (state == S_IDLE) && !irst;
  assign load_fire  = in_valid && in_ready;
  assign start_fire = start && in_ready;
  assign last_elem  = (row == RW'(M-1)) && (col == CW'(N-1));
  assign busy       = (state == S_MAC) || (state == S_SCALE) || (state == S_EMIT);
  assign done       = (state == S_DONE);

  assign a_idx = AAW'(row) * AAW'(K) + AAW'(kk);
  assign b_idx = BAW'(kk) * BAW'(N) + BAW'(col);
  assign c_idx = CAW'(row) * CAW'(N) + CAW'(col);

  // Sign-extending size casts keep the products exact at full width.
  assign a_x  = AW'(a_mem[a_idx]);
  assign b_x  = AW'(b_mem[b_idx]);
  assign prod = a_x * b_x;

  assign alpha_x = VW'(alpha_q);
  assign beta_x  = VW'(beta_q);
  assign acc_x   = VW'(acc);
  assign c_x     = VW'(c_mem[c_idx]);
  assign v       = alpha_x * acc_x + beta_x * c_x;

  // v fits the DW-bit signed range only when all bits from the DW-1 sign bit upwards agree.
  assign v_ovf = !((&v[VW-1:DW-1]) || !(|v[VW-1:DW-1]));

  // Clamp to the signed limits or keep the low bits.
  always_comb begin
    v_res = v[DW-1:0];
    if (v_ovf && sat_q) begin
      v_res = v[VW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end
  end

  // Operand storage: written at the current pointer and never reset.
  always_ff @(posedge iclk) begin
    if (load_fire) begin
      case (in_sel)
        2'd0:    a_mem[a_wp] <= in_data;
        2'd1:    b_mem[b_wp] <= in_data;
        2'd2:    c_mem[c_wp] <= in_data;
        default: ;
      endcase
    end
  end

  // Row-major write pointers. A start clears them after any coincident beat is stored.
  always_ff @(posedge iclk) begin
    if (irst || start_fire) begin
      a_wp <= '0;
      b_wp <= '0;
      c_wp <= '0;
    end else if (load_fire) begin
      case (in_sel)
        2'd0:    a_wp <= (a_wp == AAW'(M*K-1)) ? '0 : a_wp + AAW'(1);
        2'd1:    b_wp <= (b_wp == BAW'(K*N-1)) ? '0 : b_wp + BAW'(1);
        2'd2:    c_wp <= (c_wp == CAW'(M*N-1)) ? '0 : c_wp + CAW'(1);
        default: ;
      endcase
    end
  end

  // Sequencer: per element, MAC for K cycles, SCALE once, then EMIT until accepted.
  always_ff @(posedge iclk) begin
    if (irst) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_row   <= '0;
      out_col   <= '0;
      ovf       <= 1'b0;
      alpha_q   <= '0;
      beta_q    <= '0;
      sat_q     <= 1'b0;
      row       <= '0;
      col       <= '0;
      kk        <= '0;
      acc       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_fire) begin
            alpha_q <= alpha;
            beta_q  <= beta;
            sat_q   <= sat_en;
            ovf     <= 1'b0;
            row     <= '0;
            col     <= '0;
            kk      <= '0;
            acc     <= '0;
            state   <= S_MAC;
          end
        end
        S_MAC: begin
          acc <= acc + prod;
          if (kk == KW'(K-1)) begin
            kk    <= '0;
            state <= S_SCALE;
          end else begin
            kk <= kk + KW'(1);
          end
        end
        S_SCALE: begin
          out_data  <= v_res;
          out_row   <= row;
          out_col   <= col;
          out_valid <= 1'b1;
          if (v_ovf) ovf <= 1'b1;
          state <= S_EMIT;
        end
        S_EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (last_elem) begin
              state <= S_DONE;
            end else begin
              if (col == CW'(N-1)) begin
                col <= '0;
                row <= row + RW'(1);
              end else begin
                col <= col + CW'(1);
              end
              acc   <= '0;
              kk    <= '0;
              state <= S_MAC;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gemm_seq_engine.sv
// Self-checking bench for gemm_seq_engine (M=N=K=4, 32-bit data).
// A wide-integer reference model fills a scoreboard queue at each start.
// The drained outputs are popped and compared against it.
module tb_gemm_seq_engine;

  localparam int DW = 32;
  localparam int M  = 4;
  localparam int K  = 4;
  localparam int N  = 4;
  localparam int RW = (M > 1) ? $clog2(M) : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int ELEM_CYC = K + 2;

  typedef struct packed {
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic [DW-1:0] data;
  } res_t;

  logic          iclk = 1'b0;
  logic          irst;
  logic [DW-1:0] alpha;
  logic [DW-1:0] beta;
  logic          sat_en;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_sel;
  logic [DW-1:0] in_data;
  logic          start;
  logic          busy;
  logic          done;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [RW-1:0] out_row;
  logic [CW-1:0] out_col;
  logic          ovf;

  gemm_seq_engine #(.DATA_WIDTH(DW), .M(M), .K(K), .N(N)) dut (
    .iclk(iclk), .irst(irst), .alpha(alpha), .beta(beta), .sat_en(sat_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
    .start(start), .busy(busy), .done(done), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_row(out_row),
    .out_col(out_col), .ovf(ovf)
  );

  always #5 iclk = ~iclk;

  // cyc equals the number of rising edges seen so far.
  int cyc = 0;
  always @(posedge iclk) cyc <= cyc + 1;

  int total  = 0;
  int passed = 0;

  logic signed [DW-1:0] ma [M*K];
  logic signed [DW-1:0] mb [K*N];
  logic signed [DW-1:0] mc [M*N];

  res_t exp_q[$];
  res_t obs_q[$];
  logic exp_ovf;
  int   start_cyc;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion earlier");
    $fatal(1);
  end

  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  task automatic load_beat(input logic [1:0] sel, input logic [DW-1:0] data);
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = data;
    tick();
    in_valid = 1'b0;
  endtask

  // Reference: exact arithmetic at 160 bits, then clamp or wrap.
  task automatic build_expected(input logic signed [DW-1:0] a, input logic signed [DW-1:0] b, input logic s);
    logic signed [159:0] acc, v, a_w, b_w, c_w, x, y, hi, lo;
    res_t r;
    hi = (160'sd1 <<< (DW-1)) - 160'sd1;
    lo = -hi - 160'sd1;
    exp_q.delete();
    exp_ovf = 1'b0;
    for (int i = 0; i < M; i++) begin
      for (int j = 0; j < N; j++) begin
        acc = '0;
        for (int k = 0; k < K; k++) begin
          x = ma[i*K+k];
          y = mb[k*N+j];
          acc = acc + x * y;
        end
        a_w = a;
        b_w = b;
        c_w = mc[i*N+j];
        v = a_w * acc + b_w * c_w;
        r.row = RW'(i);
        r.col = CW'(j);
        if (v > hi) begin
          exp_ovf = 1'b1;
          r.data = s ? hi[DW-1:0] : v[DW-1:0];
        end else if (v < lo) begin
          exp_ovf = 1'b1;
          r.data = s ? lo[DW-1:0] : v[DW-1:0];
        end else begin
          r.data = v[DW-1:0];
        end
        exp_q.push_back(r);
      end
    end
  endtask

  task automatic do_start(input logic signed [DW-1:0] a, input logic signed [DW-1:0] b, input logic s);
    alpha  = a;
    beta   = b;
    sat_en = s;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    start_cyc = cyc;
    build_expected(a, b, s);
  endtask

  // Collects accepted results until done; mode 0 = out_ready held high, mode 1 = 1,0,0 pattern.
  // alpha/beta/sat_en are scrambled every cycle; the latched values must be used.
  task automatic drain(input int mode, input bit mid_start, output int done_at, output int first_v,
                       output int stalls, output int hold_err, output int rdy_hi, output int busy_err);
    res_t h, o;
    bit   held;
    int   n;
    done_at = -1; first_v = -1; stalls = 0; hold_err = 0; rdy_hi = 0; busy_err = 0;
    held = 1'b0; n = 0;
    h = '0;
    obs_q.delete();
    while (n < 4*M*N*ELEM_CYC + 100) begin
      out_ready = (mode == 0) ? 1'b1 : (n % 3 == 0);
      start     = mid_start && (n == 20);
      alpha     = $urandom();
      beta      = $urandom();
      sat_en    = 1'($urandom_range(0, 1));
      @(negedge iclk);
      if (in_ready) rdy_hi++;
      if (held) begin
        if (!out_valid || out_data !== h.data || out_row !== h.row || out_col !== h.col) hold_err++;
        held = 1'b0;
      end
      if (out_valid) begin
        if (first_v < 0) first_v = cyc;
        o.row = out_row;
        o.col = out_col;
        o.data = out_data;
        if (out_ready) obs_q.push_back(o);
        else begin
          held = 1'b1;
          h = o;
          stalls++;
        end
      end
      if (done) begin
        done_at = cyc;
        if (busy) busy_err++;
        break;
      end
      if (!busy) busy_err++;
      @(posedge iclk);
      #1;
      n++;
    end
    start = 1'b0;
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    irst = 1'b1; in_valid = 1'b0; in_sel = 2'd0; in_data = '0; start = 1'b0;
    out_ready = 1'b1; alpha = '0; beta = '0; sat_en = 1'b0;
    repeat (3) tick();
    total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b, required 0", in_ready); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b, required 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done: got %b, required 0", done); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b, required 0", out_valid); else passed++;
    total++; if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b, required 0", ovf); else passed++;
    total++; if (out_data !== '0) $display("FAIL reset_out_data: got %h, required 0", out_data); else passed++;
    total++; if (out_row !== '0 || out_col !== '0) $display("FAIL reset_tags: got %0d/%0d, required 0/0", out_row, out_col); else passed++;
    irst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_release_in_ready: got %b, required 1", in_ready); else passed++;
    tick();
  endtask

  task automatic test_identity();
    int d, f, st, he, rh, be;
    res_t e, o;
    for (int i = 0; i < M*K; i++) begin
      ma[i] = ((i / K) == (i % K)) ? 32'sd1 : 32'sd0;
      load_beat(2'd0, ma[i]);
    end
    load_beat(2'd3, 32'd999);
    for (int i = 0; i < K*N; i++) begin mb[i] = DW'(i + 1); load_beat(2'd1, mb[i]); end
    for (int i = 0; i < M*N; i++) begin mc[i] = '0; load_beat(2'd2, mc[i]); end
    do_start(32'sd1, 32'sd0, 1'b0);
    drain(0, 1'b0, d, f, st, he, rh, be);
    total++; if (obs_q.size() != M*N) $display("FAIL identity_count: got %0d outputs, required %0d", obs_q.size(), M*N); else passed++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) $display("FAIL identity_elem: got no output, required %h", e);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL identity_elem: got row/col/data %h, required %h", o, e); else passed++;
      end
    end
    total++; if (ovf !== 1'b0) $display("FAIL identity_ovf: got %b, required 0", ovf); else passed++;
  endtask

  task automatic test_scaling();
    int d, f, st, he, rh, be;
    res_t e, o;
    for (int i = 0; i < M*K; i++) begin ma[i] = 32'sd2; load_beat(2'd0, ma[i]); end
    for (int i = 0; i < K*N; i++) begin mb[i] = 32'sd2; load_beat(2'd1, mb[i]); end
    for (int i = 0; i < M*N-1; i++) begin mc[i] = 32'sd5; load_beat(2'd2, mc[i]); end
    // Last C beat shares its cycle with start: it must still be written.
    mc[M*N-1] = 32'sd5;
    in_valid = 1'b1; in_sel = 2'd2; in_data = 32'd5;
    do_start(32'sd3, -32'sd1, 1'b0);
    in_valid = 1'b0;
    drain(0, 1'b0, d, f, st, he, rh, be);
    total++; if (obs_q.size() == 0 || obs_q[$].data !== 32'd43) $display("FAIL scaling_last_value: got %0d outputs, required last data 43", obs_q.size()); else passed++;
    total++; if (obs_q.size() != M*N) $display("FAIL scaling_count: got %0d outputs, required %0d", obs_q.size(), M*N); else passed++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) $display("FAIL scaling_elem: got no output, required %h", e);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL scaling_elem: got row/col/data %h, required %h", o, e); else passed++;
      end
    end
    total++; if (ovf !== 1'b0) $display("FAIL scaling_ovf: got %b, required 0", ovf); else passed++;
  endtask

  task automatic test_saturation();
    int d, f, st, he, rh, be;
    res_t e, o;
    logic [DW-1:0] want;
    for (int i = 0; i < M*K; i++) begin ma[i] = 32'sh7FFFFFFF; load_beat(2'd0, ma[i]); end
    for (int i = 0; i < K*N; i++) begin mb[i] = 32'sh7FFFFFFF; load_beat(2'd1, mb[i]); end
    for (int i = 0; i < M*N; i++) begin mc[i] = '0; load_beat(2'd2, mc[i]); end
    for (int pass = 0; pass < 2; pass++) begin
      // Second pass reuses the buffers without reloading.
      do_start(32'sd1, 32'sd0, (pass == 0));
      drain(0, 1'b0, d, f, st, he, rh, be);
      want = (pass == 0) ? 32'h7FFFFFFF : 32'h00000004;
      total++; if (obs_q.size() == 0 || obs_q[0].data !== want) $display("FAIL sat_value pass %0d: got %0d outputs, required first data %h", pass, obs_q.size(), want); else passed++;
      total++; if (obs_q.size() != M*N) $display("FAIL sat_count pass %0d: got %0d outputs, required %0d", pass, obs_q.size(), M*N); else passed++;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if (obs_q.size() == 0) $display("FAIL sat_elem pass %0d: got no output, required %h", pass, e);
        else begin
          o = obs_q.pop_front();
          if (o !== e) $display("FAIL sat_elem pass %0d: got row/col/data %h, required %h", pass, o, e); else passed++;
        end
      end
      total++; if (ovf !== 1'b1) $display("FAIL sat_ovf pass %0d: got %b, required 1", pass, ovf); else passed++;
    end
  endtask

  task automatic test_throughput();
    int d, f, st, he, rh, be;
    res_t e, o;
    // Partial A load; start must rewind the A pointer for the next full reload.
    ma[0] = 32'sd7; ma[1] = -32'sd3; ma[2] = 32'sd5;
    for (int i = 0; i < 3; i++) load_beat(2'd0, ma[i]);
    do_start(32'sd2, 32'sd1, 1'b1);
    drain(0, 1'b1, d, f, st, he, rh, be);
    // first out_valid is seen in the cycle that ends at edge start+K+2
    total++; if (f - start_cyc != K + 1) $display("FAIL tput_first_valid: got offset %0d, required %0d", f - start_cyc, K + 1); else passed++;
    // done is high in the cycle that ends at edge start+M*N*(K+2)+1
    total++; if (d < 0 || d - start_cyc != M*N*ELEM_CYC) $display("FAIL tput_done: got offset %0d (done_at %0d), required %0d", d - start_cyc, d, M*N*ELEM_CYC); else passed++;
    total++; if (rh != 0) $display("FAIL tput_in_ready: got %0d cycles high during run, required 0", rh); else passed++;
    total++; if (be != 0) $display("FAIL tput_busy: got %0d busy errors, required 0", be); else passed++;
    total++; if (obs_q.size() != M*N) $display("FAIL tput_count: got %0d outputs, required %0d", obs_q.size(), M*N); else passed++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) $display("FAIL tput_elem: got no output, required %h", e);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL tput_elem: got row/col/data %h, required %h", o, e); else passed++;
      end
    end
    total++; if (ovf !== exp_ovf) $display("FAIL tput_ovf: got %b, required %b", ovf, exp_ovf); else passed++;
  endtask

  task automatic test_back_pressure();
    int d, f, st, he, rh, be;
    res_t e, o;
    for (int i = 0; i < M*K; i++) begin ma[i] = DW'(int'($urandom_range(0, 100)) - 50); load_beat(2'd0, ma[i]); end
    for (int i = 0; i < K*N; i++) begin mb[i] = DW'(int'($urandom_range(0, 100)) - 50); load_beat(2'd1, mb[i]); end
    for (int i = 0; i < M*N; i++) begin mc[i] = DW'(int'($urandom_range(0, 100)) - 50); load_beat(2'd2, mc[i]); end
    do_start(-32'sd7, 32'sd3, 1'b0);
    drain(1, 1'b0, d, f, st, he, rh, be);
    total++; if (st == 0) $display("FAIL bp_stalls: got %0d stall cycles, required at least 1", st); else passed++;
    total++; if (d < 0 || d - start_cyc != M*N*ELEM_CYC + st) $display("FAIL bp_done: got offset %0d, required %0d", d - start_cyc, M*N*ELEM_CYC + st); else passed++;
    total++; if (he != 0) $display("FAIL bp_hold: got %0d unstable stalled cycles, required 0", he); else passed++;
    total++; if (obs_q.size() != M*N) $display("FAIL bp_count: got %0d outputs, required %0d", obs_q.size(), M*N); else passed++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) $display("FAIL bp_elem: got no output, required %h", e);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL bp_elem: got row/col/data %h, required %h", o, e); else passed++;
      end
    end
    total++; if (ovf !== exp_ovf) $display("FAIL bp_ovf: got %b, required %b", ovf, exp_ovf); else passed++;
  endtask

  task automatic test_reset_mid_run();
    int d, f, st, he, rh, be, done_seen, valid_seen;
    res_t e, o;
    do_start(32'sd1, 32'sd1, 1'b0);
    out_ready = 1'b1;
    // Four elements complete, then two cycles into the fifth element's MAC.
    repeat (4*ELEM_CYC + 2) tick();
    total++; if (busy !== 1'b1) $display("FAIL rst_mid_pre_busy: got %b, required 1", busy); else passed++;
    irst = 1'b1;
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL rst_mid_out_valid: got %b, required 0", out_valid); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rst_mid_busy: got %b, required 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL rst_mid_done: got %b, required 0", done); else passed++;
    irst = 1'b0;
    done_seen = 0; valid_seen = 0;
    repeat (10) begin
      @(negedge iclk);
      if (done) done_seen++;
      if (out_valid) valid_seen++;
    end
    total++; if (done_seen != 0 || valid_seen != 0) $display("FAIL rst_mid_quiet: got done %0d valid %0d cycles, required 0/0", done_seen, valid_seen); else passed++;
    for (int i = 0; i < M*K; i++) begin ma[i] = DW'(int'($urandom_range(0, 2000)) - 1000); load_beat(2'd0, ma[i]); end
    for (int i = 0; i < K*N; i++) begin mb[i] = DW'(int'($urandom_range(0, 2000)) - 1000); load_beat(2'd1, mb[i]); end
    for (int i = 0; i < M*N; i++) begin mc[i] = DW'(int'($urandom_range(0, 2000)) - 1000); load_beat(2'd2, mc[i]); end
    do_start(32'sd2, -32'sd1, 1'b1);
    drain(0, 1'b0, d, f, st, he, rh, be);
    total++; if (d < 0 || d - start_cyc != M*N*ELEM_CYC) $display("FAIL rst_rerun_done: got offset %0d, required %0d", d - start_cyc, M*N*ELEM_CYC); else passed++;
    total++; if (obs_q.size() != M*N) $display("FAIL rst_rerun_count: got %0d outputs, required %0d", obs_q.size(), M*N); else passed++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) $display("FAIL rst_rerun_elem: got no output, required %h", e);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL rst_rerun_elem: got row/col/data %h, required %h", o, e); else passed++;
      end
    end
    total++; if (ovf !== exp_ovf) $display("FAIL rst_rerun_ovf: got %b, required %b", ovf, exp_ovf); else passed++;
  endtask

  initial begin
    test_reset();
    test_identity();
    test_scaling();
    test_saturation();
    test_throughput();
    test_back_pressure();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/gemm_seq_engine.md
# gemm_seq_engine

Parametrised, sequential GEMM engine computing R = alpha·(A×B) + beta·C over signed integer matrices of configurable dimensions, replacing the fixed 4×4 all-parallel `gemm_top` datapath. Operands are streamed in through a valid/ready load port into internal buffers. A single multiply-accumulate lane computes each result element in turn. Results leave through a valid/ready output port with row/column tags, optional saturation and a sticky overflow flag.

## Interface
- `DATA_WIDTH`, 32, element, alpha and beta width (signed two's complement)
- `M`, 4, rows of A, C and R
- `K`, 4, columns of A and rows of B
- `N`, 4, columns of B, C and R
- `ACC_WIDTH`, 2*DATA_WIDTH+$clog2(K)+1, dot-product accumulator width
- `iclk` in 1: single clock, rising edge
- `irst` in 1: synchronous, active-high reset
- `alpha` in DATA_WIDTH: scale for A×B, sampled on the accepted `start`
- `beta` in DATA_WIDTH: scale for C, sampled on the accepted `start`
- `sat_en` in 1: 1 = saturate results, 0 = wrap; sampled on the accepted `start`
- `in_valid` in 1: load beat valid
- `in_ready` out 1: load beat accepted when `in_valid && in_ready`
- `in_sel` in 2: target buffer; 0 = A, 1 = B, 2 = C, 3 = discard
- `in_data` in DATA_WIDTH: element, loaded row-major
- `start` in 1: begin computation
- `busy` out 1: high from the accepted `start` until `done`
- `done` out 1: one-cycle pulse at the end of a run
- `out_valid` out 1: result element valid
- `out_ready` in 1: result accepted when `out_valid && out_ready`
- `out_data` out DATA_WIDTH: result element
- `out_row` out $clog2(M) (min 1): row index of `out_data`
- `out_col` out $clog2(N) (min 1): column index of `out_data`
- `ovf` out 1: sticky; set if any element of the run saturated or wrapped

## Operation
- States: IDLE, MAC, SCALE, EMIT, DONE.
- **Loading (IDLE)**
  - `in_ready` = 1 only in IDLE.
  - Each buffer has its own write pointer and is written row-major.
  - Pointer wrap: A wraps after M·K beats, B after K·N, C after M·N.
  - `in_sel`=3 beats are accepted and dropped.
- **Start**
  - `start` is honoured only in IDLE and is ignored in all other states.
  - On the accepted `start`: latch `alpha`, `beta` and `sat_en`; clear `ovf`; reset all three write pointers to 0; set (i, j) = (0, 0); go to MAC.
  - If `in_valid` and `start` coincide, the load beat is written first; the pointers then reset for the next load.
- **MAC** (K cycles, k = 0..K-1)
  - acc = Σ A[i][k]·B[k][j].
  - Signed; acc is cleared on entry.
- **SCALE** (1 cycle)
  - v = alpha·acc + beta·C[i][j], computed at full width (ACC_WIDTH+DATA_WIDTH+1).
  - If v lies outside the DATA_WIDTH signed range: with `sat_en`=1, clamp to max or min; with `sat_en`=0, keep the low DATA_WIDTH bits. Either case sets `ovf`.
- **EMIT**
  - `out_valid` = 1 with data, row and column held stable until the handshake.
  - On the handshake: if (i, j) = (M-1, N-1), go to DONE; otherwise advance j, wrapping into i, and go to MAC.
  - Output order is row-major.
- **DONE**
  - `done` = 1 for one cycle, then return to IDLE.
  - `busy` is high in MAC, SCALE and EMIT and low in DONE.
- **Buffers**
  - Buffers retain contents across runs.
  - A run started without reloading reuses the previous operands.

## Timing
- Reset values:
  - `in_ready`=0 during reset and 1 on the first cycle after it.
  - `busy`, `done`, `out_valid`, `ovf`, `out_data`, `out_row`, `out_col` = 0.
  - Write pointers = 0; state = IDLE.
  - Buffer storage is not reset.
- `irst` asserted in any state: IDLE on the next edge.
  - `out_valid` drops and no `done` is issued.
  - The in-flight result is lost.
- With `out_ready` held at 1, each element takes K+2 cycles.
  - The first `out_valid` appears K+2 cycles after the `start` edge.
  - `done` is asserted M·N·(K+2)+1 cycles after the `start` edge.
- Back-pressure: each cycle of `out_ready`=0 in EMIT stalls the whole engine by one cycle.
- `alpha`, `beta` and `sat_en` changing during a run have no effect.

## Test plan
- **Identity:** A = I, B = 1..16 row-major, C = 0, alpha=1, beta=0, M=N=K=4 -> 16 outputs equal to 1..16 in row-major order with correct `out_row`/`out_col`; `ovf`=0.
- **Scaling:** A = B = all 2, C = all 5, alpha=3, beta=-1 -> every output = 3·16 - 5 = 43.
- **Saturation:** A = B = all 0x7FFFFFFF, C = 0, alpha=1.
  - `sat_en`=1 -> every output = 0x7FFFFFFF, `ovf`=1.
  - `sat_en`=0 -> every output = low 32 bits of 4·(2³¹-1)², `ovf`=1.
- **Back-pressure:** `out_ready` toggles 1,0,0,1,… -> each element is held stable while stalled, there are no duplicates or drops, and `done` arrives late by exactly the number of stall cycles.
- **Throughput and start handling:** `out_ready`=1 -> `done` arrives at `start`+M·N·(K+2)+1; a second `start` pulsed mid-run is ignored; `in_ready`=0 throughout the run.
- **Reset mid-run:** assert `irst` during the 5th element's MAC -> next cycle IDLE, `out_valid`=0, no `done`; reload and rerun gives correct results.
